cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle instruction sequencer for the 4-bit-opcode CPU core. It fetches 16-bit instruction words over a req/ack port, decodes the opcode into an ALU operation and register-file addresses, and sequences execute and write-back. It also owns the PC, conditional skip and halt. It sits between instruction memory and the ALU/register-file datapath.

## Interface
- `ADDR_W`, 8: instruction address width; PC wraps modulo 2^ADDR_W.
- `RESET_PC`, 0: PC value after reset.
- `i_clk` in 1: single clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_run` in 1: allows fetching new instructions.
- `o_imem_req` out 1: fetch request.
- `o_imem_addr` out ADDR_W: fetch address, equal to PC.
- `i_imem_ack` in 1: fetch data valid this cycle.
- `i_imem_data` in 16: instruction word. Fields: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] unused.
- `o_alu_op` out 4: ALU operation (`ALU_*` encoding).
- `o_rf_ra` out 4: read port A address (rd).
- `o_rf_rb` out 4: read port B address (rs).
- `o_rf_wa` out 4: write address (rd).
- `o_rf_we` out 1: register-file write strobe.
- `i_alu_z` in 1: ALU zero flag, valid in EXEC.
- `o_pc` out ADDR_W: current PC.
- `o_busy` out 1: high in any state other than IDLE or HALT.
- `o_halted` out 1: high in HALT.

## Operation
- States and transitions:
  - IDLE → FETCH when `i_run`=1.
  - FETCH → DECODE on the cycle `i_imem_ack`=1; the instruction register (IR) latches `i_imem_data` on that edge.
  - DECODE → HALT if opcode = `OP_HLT`; otherwise → EXEC.
  - EXEC → WB.
  - WB → FETCH if `i_run`=1; otherwise → IDLE.
  - HALT is terminal until reset.
- Decode:
  - Every `OP_*` maps to its `ALU_*`.
  - Undefined opcodes map to `ALU_NOP`, write no register, and advance the PC.
  - `OP_HLT` = 4'hF is a new define.
- Write-back: `o_rf_we`=1 for exactly one cycle in WB, for all ops except NOP, `OP_CND` and undefined opcodes.
- Conditional (`OP_CND`): `i_alu_z` is sampled at the end of EXEC. If it is 1, the PC advances by 2 in WB (skips the next instruction); otherwise it advances by 1. No register write.
- PC arithmetic is ADDR_W-bit unsigned and wraps: 0xFF+1 = 0x00 and 0xFF+2 = 0x01 for ADDR_W=8.
- `i_run` deasserted mid-instruction: the current instruction completes through WB, then the block goes to IDLE. `i_run` is ignored in HALT.

## Timing
- Reset values: `o_imem_req`=0, `o_imem_addr`=`o_pc`=RESET_PC, `o_alu_op`=`ALU_NOP`, `o_rf_ra`/`o_rf_rb`/`o_rf_wa`=0, `o_rf_we`=0, `o_busy`=0, `o_halted`=0. IR = 0, state = IDLE.
- Fetch handshake:
  - `o_imem_req` is high for the entire FETCH state.
  - `o_imem_addr` is stable until the ack cycle.
  - Ack may arrive in the first FETCH cycle (zero wait); wait cycles are unbounded.
  - `i_imem_ack` is ignored outside FETCH.
- Latency: 4 cycles per instruction with zero-wait memory (FETCH, DECODE, EXEC, WB).
- `o_rf_ra`/`o_rf_rb`/`o_rf_wa` come from the IR and are valid from DECODE through WB.
- `o_alu_op` is valid in EXEC and WB and is `ALU_NOP` in every other state.
- PC updates on the WB→next edge only.
- Reset asserted mid-FETCH: `o_imem_req` drops asynchronously and any pending ack is discarded.

## Structure
- Shared defines package: `OP_*` (including new `OP_HLT`), `ALU_*`, state encoding, instruction field positions.
- Sub-module `op_decode`: combinational; outputs the ALU op plus `writes_rd`, `is_cnd` and `is_hlt` flags.
- The top level holds the FSM, PC and IR registers.

## Test plan
- Reset, `i_run`=1, zero-wait memory returning `OP_ADD` rd=2 rs=3 at addr 0 → FETCH→WB takes 4 cycles; `o_alu_op`=`ALU_ADD` in EXEC and WB; `o_rf_we` pulses once with `o_rf_wa`=2; PC becomes 1.
- Ack delayed 3 cycles → `o_imem_req` held 4 cycles with `o_imem_addr` stable; instruction completes in 7 cycles.
- `OP_CND` at PC=5 with `i_alu_z`=1 → no write, next fetch at 7. Repeat with `i_alu_z`=0 → next fetch at 6.
- PC=0xFF, `OP_MOV` → next fetch address 0x00. `OP_CND` taken at 0xFF → next fetch address 0x01.
- `OP_HLT` fetched → `o_halted`=1, `o_busy`=0, no further `o_imem_req` even with `i_run`=1. Reset then restarts at RESET_PC.
- `i_run` dropped during EXEC → WB completes, state goes to IDLE, `o_busy`=0. Reset asserted during FETCH → req low the same cycle, PC=RESET_PC.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: opcode/ALU encodings, FSM state codes and instruction fields.
// Rev 1.0
`default_nettype none

package cpu_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_CND = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_OR  = 4'h4;
  localparam logic [3:0] ALU_XOR = 4'h5;
  localparam logic [3:0] ALU_MOV = 4'h6;
  localparam logic [3:0] ALU_CMP = 4'h7;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       writes_rd;
    logic       is_cnd;
    logic       is_hlt;
  } dec_t;

endpackage

`default_nettype wire

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction-fetch, decode and status signals of the sequencer.
// Rev 1.0
`default_nettype none

interface cpu_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              run;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_data;
  logic [3:0]        alu_op;
  logic [3:0]        rf_ra;
  logic [3:0]        rf_rb;
  logic [3:0]        rf_wa;
  logic              rf_we;
  logic              alu_z;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  modport master (
    input  run, imem_ack, imem_data, alu_z,
    output imem_req, imem_addr, alu_op, rf_ra, rf_rb, rf_wa, rf_we, pc, busy, halted
  );

  modport slave (
    output run, imem_ack, imem_data, alu_z,
    input  imem_req, imem_addr, alu_op, rf_ra, rf_rb, rf_wa, rf_we, pc, busy, halted
  );
endinterface

`default_nettype wire

// File: rtl/cpu_sequencer_op_decode.sv
// op_decode: combinational opcode decoder producing the ALU op and control flags.
// Rev 1.0
`default_nettype none

module op_decode
  import cpu_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '{alu_op: ALU_NOP, writes_rd: 1'b0, is_cnd: 1'b0, is_hlt: 1'b0};
    case (opcode)
      OP_NOP: dec.alu_op = ALU_NOP;
      OP_ADD: begin dec.alu_op = ALU_ADD; dec.writes_rd = 1'b1; end
      OP_SUB: begin dec.alu_op = ALU_SUB; dec.writes_rd = 1'b1; end
      OP_AND: begin dec.alu_op = ALU_AND; dec.writes_rd = 1'b1; end
      OP_OR:  begin dec.alu_op = ALU_OR;  dec.writes_rd = 1'b1; end
      OP_XOR: begin dec.alu_op = ALU_XOR; dec.writes_rd = 1'b1; end
      OP_MOV: begin dec.alu_op = ALU_MOV; dec.writes_rd = 1'b1; end
      OP_CND: begin dec.alu_op = ALU_CMP; dec.is_cnd = 1'b1; end
      OP_HLT: dec.is_hlt = 1'b1;
      // Undefined opcodes behave as NOP and still advance the PC.
      default: dec.alu_op = ALU_NOP;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/WB sequencer owning the PC, IR and halt state.
// Rev 1.0
`default_nettype none

module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_sequencer_if.master   bus
);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_step;
  logic [15:0]       r_ir;
  logic              r_z;
  logic              w_exec_or_wb;
  logic              w_unused_ir;
  dec_t              w_dec;

  op_decode u_op_decode (
    .opcode (r_ir[OPC_MSB:OPC_LSB]),
    .dec    (w_dec)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.run) w_state_nxt = ST_FETCH;
      ST_FETCH:  if (bus.imem_ack) w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = w_dec.is_hlt ? ST_HALT : ST_EXEC;
      ST_EXEC:   w_state_nxt = ST_WB;
      ST_WB:     w_state_nxt = bus.run ? ST_FETCH : ST_IDLE;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // A taken conditional skips the following instruction.
  assign w_pc_step = (w_dec.is_cnd && r_z) ? ADDR_W'(2) : ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_FETCH && bus.imem_ack)
        r_ir <= bus.imem_data;
      if (r_state == ST_EXEC)
        r_z <= bus.alu_z;
      if (r_state == ST_WB)
        r_pc <= r_pc + w_pc_step;
    end
  end

  assign w_exec_or_wb  = (r_state == ST_EXEC) || (r_state == ST_WB);
  assign w_unused_ir   = ^r_ir[3:0];

  assign bus.imem_req  = (r_state == ST_FETCH);
  assign bus.imem_addr = r_pc;
  assign bus.pc        = r_pc;
  assign bus.alu_op    = w_exec_or_wb ? w_dec.alu_op : ALU_NOP;
  assign bus.rf_ra     = r_ir[RD_MSB:RD_LSB];
  assign bus.rf_rb     = r_ir[RS_MSB:RS_LSB];
  assign bus.rf_wa     = r_ir[RD_MSB:RD_LSB];
  assign bus.rf_we     = (r_state == ST_WB) && w_dec.writes_rd;
  assign bus.busy      = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign bus.halted    = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed table-driven bench for cpu_sequencer.
// Rev 1.0
`default_nettype none

module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.ADDR_W(8)) bus ();

  cpu_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] word;
    logic        z;
    int          delay;
    logic [7:0]  pc;
    logic [3:0]  op;
    logic        we;
    logic [7:0]  next_pc;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at a falling edge with the DUT in FETCH; leaves one edge after WB.
  task automatic run_vec(input logic [15:0] word, input logic z, input int delay, input logic drop,
                         input logic [7:0] pc, input logic [3:0] op, input logic we,
                         input logic [7:0] nxt);
    check("fetch_req", bus.imem_req, 1);
    check("fetch_addr", bus.imem_addr, pc);
    for (int i = 0; i < delay; i++) begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = 16'hFFFF;
      @(negedge clk);
      check("wait_req", bus.imem_req, 1);
      check("wait_addr", bus.imem_addr, pc);
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = word;
    @(negedge clk);
    // A stray ack outside FETCH must not reload the IR.
    bus.imem_data = 16'h0000;
    bus.alu_z     = z;
    check("dec_req", bus.imem_req, 0);
    check("dec_op", bus.alu_op, ALU_NOP);
    check("dec_busy", bus.busy, 1);
    check("dec_ra", bus.rf_ra, word[11:8]);
    check("dec_rb", bus.rf_rb, word[7:4]);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("exec_op", bus.alu_op, op);
    check("exec_we", bus.rf_we, 0);
    check("exec_pc", bus.pc, pc);
    if (drop) bus.run = 1'b0;
    @(negedge clk);
    bus.alu_z = ~z;
    check("wb_op", bus.alu_op, op);
    check("wb_we", bus.rf_we, we);
    check("wb_wa", bus.rf_wa, word[11:8]);
    check("wb_pc", bus.pc, pc);
    @(negedge clk);
    bus.alu_z = 1'b0;
    check("next_pc", bus.pc, nxt);
    check("next_we", bus.rf_we, 0);
    check("next_busy", bus.busy, !drop);
    check("next_req", bus.imem_req, !drop);
  endtask

  initial begin
    logic [7:0] pc;

    tbl[0] = '{16'h1230, 1'b0, 0, 8'h00, ALU_ADD, 1'b1, 8'h01};
    tbl[1] = '{16'h2450, 1'b0, 3, 8'h01, ALU_SUB, 1'b1, 8'h02};
    tbl[2] = '{16'h7120, 1'b1, 0, 8'h02, ALU_CMP, 1'b0, 8'h04};
    tbl[3] = '{16'h7340, 1'b0, 1, 8'h04, ALU_CMP, 1'b0, 8'h05};
    tbl[4] = '{16'h7560, 1'b1, 0, 8'h05, ALU_CMP, 1'b0, 8'h07};
    tbl[5] = '{16'h7780, 1'b0, 0, 8'h07, ALU_CMP, 1'b0, 8'h08};
    tbl[6] = '{16'h9AB0, 1'b0, 2, 8'h08, ALU_NOP, 1'b0, 8'h09};
    tbl[7] = '{16'h0560, 1'b0, 0, 8'h09, ALU_NOP, 1'b0, 8'h0A};
    tbl[8] = '{16'h5EF0, 1'b0, 0, 8'h0A, ALU_XOR, 1'b1, 8'h0B};
    tbl[9] = '{16'h6120, 1'b0, 0, 8'h0B, ALU_MOV, 1'b1, 8'h0C};

    bus.run       = 1'b1;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    bus.alu_z     = 1'b0;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", bus.imem_req, 0);
    check("rst_addr", bus.imem_addr, 8'h00);
    check("rst_pc", bus.pc, 8'h00);
    check("rst_op", bus.alu_op, ALU_NOP);
    check("rst_ra", bus.rf_ra, 0);
    check("rst_rb", bus.rf_rb, 0);
    check("rst_wa", bus.rf_wa, 0);
    check("rst_we", bus.rf_we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_halted", bus.halted, 0);

    @(negedge clk);
    bus.run = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_req", bus.imem_req, 0);
    bus.run = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10; k++)
      run_vec(tbl[k].word, tbl[k].z, tbl[k].delay, 1'b0, tbl[k].pc, tbl[k].op, tbl[k].we,
              tbl[k].next_pc);

    // Walk to the top of the address space to exercise PC wrap.
    pc = 8'h0C;
    while (pc != 8'hFF) begin
      run_vec(16'h0000, 1'b0, 0, 1'b0, pc, ALU_NOP, 1'b0, pc + 8'h01);
      pc = pc + 8'h01;
    end
    run_vec(16'h6340, 1'b0, 0, 1'b0, 8'hFF, ALU_MOV, 1'b1, 8'h00);
    pc = 8'h00;
    while (pc != 8'hFF) begin
      run_vec(16'h0000, 1'b0, 0, 1'b0, pc, ALU_NOP, 1'b0, pc + 8'h01);
      pc = pc + 8'h01;
    end
    run_vec(16'h7000, 1'b1, 0, 1'b0, 8'hFF, ALU_CMP, 1'b0, 8'h01);

    // Run dropped during EXEC: instruction finishes, then IDLE ignores acks.
    run_vec(16'h3450, 1'b0, 0, 1'b1, 8'h01, ALU_AND, 1'b1, 8'h02);
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'h1230;
    @(negedge clk);
    check("drop_idle_busy", bus.busy, 0);
    check("drop_idle_req", bus.imem_req, 0);
    check("drop_idle_pc", bus.pc, 8'h02);
    bus.imem_ack = 1'b0;
    bus.run      = 1'b1;
    @(negedge clk);

    // Halt: terminal, no further fetches even with run and ack high.
    check("hlt_req", bus.imem_req, 1);
    check("hlt_addr", bus.imem_addr, 8'h02);
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'hF000;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("hlt_dec_busy", bus.busy, 1);
    @(negedge clk);
    check("hlt_halted", bus.halted, 1);
    check("hlt_busy", bus.busy, 0);
    check("hlt_op", bus.alu_op, ALU_NOP);
    check("hlt_pc", bus.pc, 8'h02);
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hlt_stay_req", bus.imem_req, 0);
      check("hlt_stay_halted", bus.halted, 1);
    end
    bus.imem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("hlt_rst_halted", bus.halted, 0);
    check("hlt_rst_pc", bus.pc, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(16'h1230, 1'b0, 0, 1'b0, 8'h00, ALU_ADD, 1'b1, 8'h01);

    // Reset mid-FETCH with an ack pending.
    @(negedge clk);
    check("mf_req", bus.imem_req, 1);
    #2;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'h1230;
    rst_n         = 1'b0;
    #1;
    check("mf_rst_req", bus.imem_req, 0);
    check("mf_rst_pc", bus.pc, 8'h00);
    check("mf_rst_busy", bus.busy, 0);
    @(negedge clk);
    bus.run = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("mf_after_busy", bus.busy, 0);
    check("mf_after_req", bus.imem_req, 0);
    check("mf_after_ra", bus.rf_ra, 0);
    bus.imem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
